// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: turns each one-hot move into a vertical leg and a horizontal leg for the command processor.
// Define TOUR_ABORT_EN to let a UART opcode 4'hF abort a running tour.
module tour_cmd_seq #(
    parameter int BRD_DIM = 5,
    parameter int NUM_MV  = BRD_DIM * BRD_DIM - 1,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err,
    output logic [2:0]       dbg_state
);

    if (BRD_DIM < 3 || BRD_DIM > 8) begin : g_bad_dim
        $error("tour_cmd_seq: BRD_DIM out of range");
    end
    if ((1 << IDX_W) < NUM_MV) begin : g_bad_idx
        $error("tour_cmd_seq: IDX_W too narrow for NUM_MV");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic             tour_err_q, tour_err_d;

    logic [7:0] v_head, h_head;
    logic [3:0] v_sq, h_sq;
    logic       last_mv;
    logic       move_ok;

    always_comb begin
        v_head = HD_N;
        v_sq   = 4'd0;
        h_head = HD_E;
        h_sq   = 4'd0;
        case (move)
            8'h01: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'h02: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'h04: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'h08: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'h10: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'h20: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'h40: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            8'h80: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            default: ;
        endcase
    end

    assign move_ok = $onehot(move);
    assign last_mv = (mv_indx_q == IDX_W'(NUM_MV - 1));

    // Handshake: cmd/cmd_rdy form a valid that stays asserted with cmd stable
    // until clr_cmd_rdy is seen; send_resp then marks that command complete.
    always_comb begin
        state_d    = state_q;
        mv_indx_d  = mv_indx_q;
        tour_err_d = tour_err_q;
        cmd        = cmd_UART;
        cmd_rdy    = 1'b0;
        resp       = 8'h5A;
        case (state_q)
            IDLE: begin
                cmd_rdy = cmd_rdy_UART;
                resp    = 8'hA5;
                if (start_tour) begin
                    state_d    = VERT;
                    mv_indx_d  = '0;
                    tour_err_d = 1'b0;
                end
            end
            VERT: begin
                if (!move_ok) begin
                    tour_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cmd     = {4'b0010, v_head, v_sq};
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) state_d = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = {4'b0011, h_head, h_sq};
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                if (last_mv) resp = 8'hA5;
                if (send_resp) begin
                    if (last_mv) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 1'b1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TOUR_ABORT_EN
        // Abort wins over any in-tour transition and leaves the error flag alone.
        if (state_q != IDLE && cmd_rdy_UART && cmd_UART[15:12] == 4'hF) begin
            state_d    = IDLE;
            mv_indx_d  = '0;
            tour_err_d = tour_err_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mv_indx_q  <= '0;
            tour_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            tour_err_q <= tour_err_d;
        end
    end

    assign mv_indx   = mv_indx_q;
    assign tour_busy = (state_q != IDLE);
    assign tour_err  = tour_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: a command-processor responder pops expected legs from a queue.
module tb_tour_cmd_seq;

    localparam int NUM_MV = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_busy;
    logic        tour_err;
    logic [2:0]  dbg_state;

    logic [7:0]  move_tab [0:31];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    tour_cmd_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .tour_busy    (tour_busy),
        .tour_err     (tour_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // the move source is addressed by the DUT's move index
    assign move = move_tab[mv_indx];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
        logic [7:0] vh, hh;
        logic [3:0] vs, hs;
        vh = 8'h00; vs = 4'd0; hh = 8'h00; hs = 4'd0;
        case (mv)
            8'h01: begin vh = 8'h00; vs = 2; hh = 8'hBF; hs = 1; end
            8'h02: begin vh = 8'h00; vs = 2; hh = 8'h3F; hs = 1; end
            8'h04: begin vh = 8'h00; vs = 1; hh = 8'h3F; hs = 2; end
            8'h08: begin vh = 8'h7F; vs = 1; hh = 8'h3F; hs = 2; end
            8'h10: begin vh = 8'h7F; vs = 2; hh = 8'h3F; hs = 1; end
            8'h20: begin vh = 8'h7F; vs = 2; hh = 8'hBF; hs = 1; end
            8'h40: begin vh = 8'h7F; vs = 1; hh = 8'hBF; hs = 2; end
            8'h80: begin vh = 8'h00; vs = 1; hh = 8'hBF; hs = 2; end
            default: ;
        endcase
        return horiz ? {4'h3, hh, hs} : {4'h2, vh, vs};
    endfunction

    task automatic push_moves(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(leg_cmd(move_tab[i], 1'b0));
            exp_q.push_back(leg_cmd(move_tab[i], 1'b1));
        end
    endtask

    task automatic begin_tour();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        #1;
        check_eq("start_busy", 32'(tour_busy), 32'd1);
        check_eq("start_err_clr", 32'(tour_err), 32'd0);
    endtask

    task automatic run_leg(input int idx, input bit horiz, input bit collide, input bit hold_resp);
        int n;
        logic [15:0] exp_cmd;
        logic [7:0] exp_resp;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 16) begin
            @(negedge clk); #1; n++;
        end
        check_eq("leg_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        check_eq("leg_cmd", 32'(cmd), 32'(exp_cmd));
        check_eq("leg_mv_indx", 32'(mv_indx), 32'(idx));
        check_eq("leg_resp", 32'(resp), 32'h5A);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            check_eq("leg_hold", 32'(cmd_rdy), 32'd1);
        end
        clr_cmd_rdy = 1'b1;
        send_resp   = collide;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        #1;
        exp_resp = (horiz && idx == NUM_MV - 1) ? 8'hA5 : 8'h5A;
        check_eq("wait_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check_eq("wait_resp", 32'(resp), 32'(exp_resp));
        if (collide) begin
            repeat (2) begin
                @(negedge clk); #1;
                check_eq("collide_wait", 32'(cmd_rdy), 32'd0);
            end
        end
        if (idx == 5 && !horiz) begin
            start_tour = 1'b1;
            @(negedge clk);
            start_tour = 1'b0;
            #1;
            check_eq("start_ignored", 32'(cmd_rdy), 32'd0);
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
        end
        if (!hold_resp) begin
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
            #1;
        end
    endtask

    task automatic check_idle_after_tour();
        check_eq("end_busy", 32'(tour_busy), 32'd0);
        check_eq("end_resp", 32'(resp), 32'hA5);
        check_eq("end_cmd_pass", 32'(cmd), 32'h4000);
        check_eq("end_cmd_rdy_pass", 32'(cmd_rdy), 32'd1);
        check_eq("end_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        check_eq("watchdog", 32'd0, 32'(checks));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        cmd_UART     = 16'h4000;
        cmd_rdy_UART = 1'b1;
        for (int i = 0; i < 32; i++) move_tab[i] = 8'h01;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy", 32'(tour_busy), 32'd0);
        check_eq("rst_mv_indx", 32'(mv_indx), 32'd0);
        check_eq("rst_err", 32'(tour_err), 32'd0);
        check_eq("rst_resp", 32'(resp), 32'hA5);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_eq("idle_cmd", 32'(cmd), 32'h4000);
        check_eq("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);
        cmd_rdy_UART = 1'b0;
        #1;
        check_eq("idle_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        cmd_rdy_UART = 1'b1;
        #1;

        // tour A: every move is 8'h01, one clr/send_resp collision
        push_moves(NUM_MV);
        begin_tour();
        for (int i = 0; i < NUM_MV; i++) begin
            run_leg(i, 1'b0, (i == 7), 1'b0);
            run_leg(i, 1'b1, 1'b0, 1'b0);
        end
        check_idle_after_tour();

        // tour B: random legal moves, first move 8'h04
        for (int i = 0; i < NUM_MV; i++) move_tab[i] = 8'h01 << $urandom_range(0, 7);
        move_tab[0] = 8'h04;
        push_moves(NUM_MV);
        begin_tour();
        for (int i = 0; i < NUM_MV; i++) begin
            run_leg(i, 1'b0, ($urandom_range(0, 7) == 0), 1'b0);
            run_leg(i, 1'b1, ($urandom_range(0, 7) == 0), 1'b0);
        end
        check_idle_after_tour();

        // tour C: illegal move at index 3
        for (int i = 0; i < 3; i++) move_tab[i] = 8'h01 << $urandom_range(0, 7);
        move_tab[3] = 8'h03;
        push_moves(3);
        begin_tour();
        for (int i = 0; i < 3; i++) begin
            run_leg(i, 1'b0, 1'b0, 1'b0);
            run_leg(i, 1'b1, 1'b0, 1'b0);
        end
        check_eq("bad_no_cmd_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk); #1;
        check_eq("bad_err", 32'(tour_err), 32'd1);
        check_eq("bad_busy", 32'(tour_busy), 32'd0);
        check_eq("bad_mv_indx", 32'(mv_indx), 32'd3);
        check_eq("bad_cmd_rdy_pass", 32'(cmd_rdy), 32'd1);
        cmd_rdy_UART = 1'b0;
        #1;
        check_eq("bad_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        cmd_rdy_UART = 1'b1;
        @(negedge clk); #1;
        check_eq("bad_err_sticky", 32'(tour_err), 32'd1);

        // reset while waiting on the horizontal leg of move 10
        for (int i = 0; i < NUM_MV; i++) move_tab[i] = 8'h01 << $urandom_range(0, 7);
        push_moves(11);
        begin_tour();
        for (int i = 0; i < 11; i++) begin
            run_leg(i, 1'b0, 1'b0, 1'b0);
            run_leg(i, 1'b1, 1'b0, (i == 10));
        end
        check_eq("pre_rst_mv_indx", 32'(mv_indx), 32'd10);
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst_busy", 32'(tour_busy), 32'd0);
        check_eq("midrst_mv_indx", 32'(mv_indx), 32'd0);
        check_eq("midrst_resp", 32'(resp), 32'hA5);
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("midrst_stay_idle", 32'(tour_busy), 32'd0);
        end

        // UART abort command while waiting on a vertical leg
        for (int i = 0; i < NUM_MV; i++) move_tab[i] = 8'h80;
        push_moves(2);
        begin_tour();
        run_leg(0, 1'b0, 1'b0, 1'b0);
        run_leg(0, 1'b1, 1'b0, 1'b0);
        run_leg(1, 1'b0, 1'b0, 1'b1);
        cmd_UART = 16'hF000;
        @(negedge clk); #1;
`ifdef TOUR_ABORT_EN
        check_eq("abort_busy", 32'(tour_busy), 32'd0);
        check_eq("abort_cmd", 32'(cmd), 32'hF000);
        check_eq("abort_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check_eq("abort_mv_indx", 32'(mv_indx), 32'd0);
        check_eq("abort_err", 32'(tour_err), 32'd0);
        cmd_UART = 16'h4000;
`else
        check_eq("noabort_busy", 32'(tour_busy), 32'd1);
        check_eq("noabort_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check_eq("noabort_mv_indx", 32'(mv_indx), 32'd1);
        cmd_UART = 16'h4000;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        #1;
        run_leg(1, 1'b1, 1'b0, 1'b0);
        check_eq("noabort_next_mv", 32'(mv_indx), 32'd2);
`endif
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
